td4_imem_loader: RTL and testbench

Instruction-memory responder for the td4_core fetch interface. Returns `op` for the core's `ip` in the same cycle, holds 16 program bytes, and loads them from a byte-wide valid/ready stream. The core is held in reset during loading and released when loading completes. Sits beside td4_core at the top level, in place of a fixed program array.

---
 rtl/td4_pkg.sv | 28 ++
 rtl/td4_imem.sv | 52 +++++
 rtl/td4_imem_loader.sv | 161 ++++++++++++++++
 tb/tb_td4_imem_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : td4_pkg
//  Description : Shared constants and types for the td4 instruction-memory
//                loader and its register file.
//                  TD4_IP_W          width of the core instruction pointer
//                  TD4_OP_W          width of one instruction byte
//                  TD4_MEM_DEPTH     number of program words
//                  td4_imem_state_t  loader control states
//  Revision    : 1.0  initial release
// ============================================================================
package td4_pkg;

    localparam int TD4_IP_W      = 4;
    localparam int TD4_OP_W      = 8;
    localparam int TD4_MEM_DEPTH = 16;

    // IDLE : core held in reset, memory frozen
    // LOAD : accepting program bytes, core held in reset
    // RUN  : core released, memory frozen
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } td4_imem_state_t;

endpackage : td4_pkg
`default_nettype wire

// File: rtl/td4_imem.sv
`default_nettype none
// ============================================================================
//  Module      : td4_imem
//  Description : Small register-file program memory for td4_core.
//                One synchronous write port, one combinational read port.
//                All words clear to zero while rst_n is low.
//  Ports       :
//    clk    in   system clock
//    rst_n  in   asynchronous active-low clear of every word
//    we     in   write enable
//    waddr  in   write address
//    wdata  in   write data
//    raddr  in   read address
//    rdata  out  word at raddr, zero-latency
//  Revision    : 1.0  initial release
// ============================================================================
module td4_imem
    import td4_pkg::*;
#(
    parameter int DEPTH  = TD4_MEM_DEPTH,
    parameter int ADDR_W = TD4_IP_W,
    parameter int DATA_W = TD4_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Clear is asynchronous so a reset in the middle of a load throws the
    // partial image away at once rather than on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // The core fetches and executes in the same cycle, so the read path
    // must not be registered.
    assign rdata = r_mem[raddr];

endmodule : td4_imem
`default_nettype wire

// File: rtl/td4_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : td4_imem_loader
//  Description : Instruction-memory responder for the td4_core fetch port.
//                Serves op = mem[ip] combinationally, and reloads the 16-byte
//                program from a byte-wide valid/ready stream while holding
//                the core in reset. The core is released when loading ends
//                (AUTO_RUN=1) or on an explicit run_start request.
//  Parameters  :
//    AUTO_RUN    1: enter RUN after the 16th byte, 0: return to IDLE
//  Ports       :
//    clk         in   system clock
//    rst_n       in   asynchronous active-low reset
//    ip          in   core instruction pointer
//    op          out  instruction at mem[ip], combinational
//    core_rst_n  out  active-low core reset, registered, high only in RUN
//    ld_start    in   start or restart a load (single-cycle)
//    run_start   in   release the core without loading (single-cycle)
//    ld_valid    in   load byte valid
//    ld_data     in   load byte
//    ld_ready    out  a byte is accepted this cycle when ld_valid is high
//    ld_done     out  one-cycle pulse after the last byte is accepted
//    busy        out  high while loading
//  Revision    : 1.0  initial release
// ============================================================================
module td4_imem_loader
    import td4_pkg::*;
#(
    parameter bit AUTO_RUN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TD4_IP_W-1:0] ip,
    output logic [TD4_OP_W-1:0] op,
    output logic                core_rst_n,
    input  logic                ld_start,
    input  logic                run_start,
    input  logic                ld_valid,
    input  logic [TD4_OP_W-1:0] ld_data,
    output logic                ld_ready,
    output logic                ld_done,
    output logic                busy
);

    localparam logic [TD4_IP_W-1:0] c_last_addr = TD4_IP_W'(TD4_MEM_DEPTH - 1);

    td4_imem_state_t     r_state;
    td4_imem_state_t     w_state_nxt;
    logic [TD4_IP_W-1:0] r_wa;
    logic [TD4_IP_W-1:0] w_wa_nxt;
    logic                w_we;
    logic                w_done;
    logic                r_core_rst_n;
    logic                r_ld_ready;
    logic                r_busy;
    logic                r_ld_done;

    // ------------------------------------------------------------------
    // State and write-address registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wa    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wa    <= w_wa_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, address counter and write strobe
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_wa_nxt    = r_wa;
        w_we        = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            IDLE: begin
                // A load request takes priority over a run request.
                if (ld_start) begin
                    w_state_nxt = LOAD;
                    w_wa_nxt    = '0;
                end else if (run_start) begin
                    w_state_nxt = RUN;
                end
            end

            LOAD: begin
                // A restart rewinds the address and suppresses the write in
                // the same cycle; words already written are left in place.
                if (ld_start) begin
                    w_wa_nxt = '0;
                end else if (ld_valid && r_ld_ready) begin
                    w_we     = 1'b1;
                    w_wa_nxt = r_wa + 1'b1;
                    if (r_wa == c_last_addr) begin
                        w_done      = 1'b1;
                        w_state_nxt = AUTO_RUN ? RUN : IDLE;
                    end
                end
            end

            RUN: begin
                if (ld_start) begin
                    w_state_nxt = LOAD;
                    w_wa_nxt    = '0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_wa_nxt    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers, decoded from the next state so they line up with
    // the state register after every edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rst_n <= 1'b0;
            r_ld_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_ld_done    <= 1'b0;
        end else begin
            r_core_rst_n <= (w_state_nxt == RUN);
            r_ld_ready   <= (w_state_nxt == LOAD);
            r_busy       <= (w_state_nxt == LOAD);
            r_ld_done    <= w_done;
        end
    end

    assign core_rst_n = r_core_rst_n;
    assign ld_ready   = r_ld_ready;
    assign busy       = r_busy;
    assign ld_done    = r_ld_done;

    // ------------------------------------------------------------------
    // Program memory
    // ------------------------------------------------------------------
    td4_imem #(
        .DEPTH  (TD4_MEM_DEPTH),
        .ADDR_W (TD4_IP_W),
        .DATA_W (TD4_OP_W)
    ) u_imem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_we),
        .waddr (r_wa),
        .wdata (ld_data),
        .raddr (ip),
        .rdata (op)
    );

endmodule : td4_imem_loader
`default_nettype wire

// File: tb/tb_td4_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_td4_imem_loader
//  Description : Self-checking bench. Two loaders (AUTO_RUN=0 and 1) share
//                one stimulus stream; each is compared every cycle against a
//                byte-count/flag model of the loader, with literal checks at
//                the interesting points of each scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_td4_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ip = 4'd0;
    logic       ld_start = 1'b0;
    logic       run_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'h00;

    logic [7:0] op0, op1;
    logic       core_rst_n0, core_rst_n1;
    logic       ld_ready0, ld_ready1;
    logic       ld_done0, ld_done1;
    logic       busy0, busy1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    td4_imem_loader #(.AUTO_RUN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ip(ip), .op(op0), .core_rst_n(core_rst_n0),
        .ld_start(ld_start), .run_start(run_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready0), .ld_done(ld_done0), .busy(busy0)
    );

    td4_imem_loader #(.AUTO_RUN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ip(ip), .op(op1), .core_rst_n(core_rst_n1),
        .ld_start(ld_start), .run_start(run_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready1), .ld_done(ld_done1), .busy(busy1)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: "loading"/"running" flags, number of bytes taken
    // so far in the current load, and a 16-byte image. Index k selects the
    // instance (k=1 is the AUTO_RUN one).
    // ------------------------------------------------------------------
    bit         m_loading [2] = '{0, 0};
    bit         m_running [2] = '{0, 0};
    bit         m_done    [2] = '{0, 0};
    int         m_cnt     [2] = '{0, 0};
    logic [7:0] m_mem     [2][16];
    int         done_cnt  [2] = '{0, 0};

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 16; a++) m_mem[k][a] = 8'h00;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_loading[k] = 0; m_running[k] = 0; m_done[k] = 0; m_cnt[k] = 0;
                for (int a = 0; a < 16; a++) m_mem[k][a] = 8'h00;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] = 0;
                if (m_loading[k]) begin
                    if (ld_start) begin
                        m_cnt[k] = 0;
                    end else if (ld_valid) begin
                        m_mem[k][m_cnt[k]] = ld_data;
                        m_cnt[k] = m_cnt[k] + 1;
                        if (m_cnt[k] == 16) begin
                            m_cnt[k]     = 0;
                            m_done[k]    = 1;
                            m_loading[k] = 0;
                            m_running[k] = (k == 1);
                        end
                    end
                end else if (ld_start) begin
                    m_loading[k] = 1;
                    m_running[k] = 0;
                    m_cnt[k]     = 0;
                end else if (!m_running[k] && run_start) begin
                    m_running[k] = 1;
                end
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        chk("op0",   {24'h0, op0},  {24'h0, m_mem[0][ip]});
        chk("op1",   {24'h0, op1},  {24'h0, m_mem[1][ip]});
        chk("core_rst_n0", {31'h0, core_rst_n0}, {31'h0, m_running[0]});
        chk("core_rst_n1", {31'h0, core_rst_n1}, {31'h0, m_running[1]});
        chk("ld_ready0", {31'h0, ld_ready0}, {31'h0, m_loading[0]});
        chk("ld_ready1", {31'h0, ld_ready1}, {31'h0, m_loading[1]});
        chk("busy0", {31'h0, busy0}, {31'h0, m_loading[0]});
        chk("busy1", {31'h0, busy1}, {31'h0, m_loading[1]});
        chk("ld_done0", {31'h0, ld_done0}, {31'h0, m_done[0]});
        chk("ld_done1", {31'h0, ld_done1}, {31'h0, m_done[1]});
        if (ld_done0 === 1'b1) done_cnt[0]++;
        if (ld_done1 === 1'b1) done_cnt[1]++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        ip = 4'($urandom_range(0, 15));
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        int n = 0;
        bit acc = 0;
        do begin
            ld_valid = ($urandom_range(0, 99) >= stall);
            ld_data  = ld_valid ? b : 8'($urandom);
            acc      = ld_valid && m_loading[1];
            tick();
            n++;
        end while (!acc && n < 1000);
        ld_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_byte: byte %0h not accepted within 1000 cycles", b);
        end
    endtask

    task automatic pulse_ld_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    // Reads every word of both instances through ip and compares to img.
    task automatic check_image(string nm, input logic [7:0] img [16]);
        for (int a = 0; a < 16; a++) begin
            ip = 4'(a);
            #1;
            chk({nm, "_dut0"}, {24'h0, op0}, {24'h0, img[a]});
            chk({nm, "_dut1"}, {24'h0, op1}, {24'h0, img[a]});
        end
    endtask

    logic [7:0] prog  [16] = '{8'hB7, 8'h01, 8'hE1, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56,
                               8'h67, 8'h78, 8'h89, 8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hFF};
    logic [7:0] zeros [16];
    logic [7:0] fives [16];
    logic [7:0] img2  [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 16; a++) begin
            zeros[a] = 8'h00;
            fives[a] = 8'h55;
            img2[a]  = 8'($urandom);
        end

        // Reset, then idle with noise on the data stream.
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reset_core_rst_n1", {31'h0, core_rst_n1}, 32'h0);
        chk("reset_ld_ready1",   {31'h0, ld_ready1},   32'h0);
        check_image("reset_zero", zeros);
        for (int i = 0; i < 100; i++) begin
            ld_valid = 1'($urandom);
            ld_data  = 8'($urandom);
            tick();
        end
        ld_valid = 1'b0;
        chk("idle_core_rst_n0", {31'h0, core_rst_n0}, 32'h0);
        check_image("idle_zero", zeros);

        // Full back-to-back load.
        done_cnt = '{0, 0};
        pulse_ld_start();
        chk("start_ld_ready1", {31'h0, ld_ready1}, 32'h1);
        for (int i = 0; i < 16; i++) send_byte(prog[i], 0);
        chk("full_done1",  {31'h0, ld_done1},    32'h1);
        chk("full_crst1",  {31'h0, core_rst_n1}, 32'h1);
        chk("full_crst0",  {31'h0, core_rst_n0}, 32'h0);
        chk("full_ready1", {31'h0, ld_ready1},   32'h0);
        tick();
        chk("full_done_once1", done_cnt[1], 1);
        chk("full_done_once0", done_cnt[0], 1);
        ip = 4'd0;  #1; chk("full_op_ip0",  {24'h0, op1}, 32'hB7);
        ip = 4'd15; #1; chk("full_op_ip15", {24'h0, op1}, 32'hFF);

        // Same program with a stalling stream; reloads from RUN on dut1.
        done_cnt = '{0, 0};
        pulse_ld_start();
        chk("reload_crst1", {31'h0, core_rst_n1}, 32'h0);
        for (int i = 0; i < 16; i++) send_byte(prog[i], 50);
        tick();
        chk("stall_done_once1", done_cnt[1], 1);
        check_image("stall_image", prog);

        // Restart mid-load; the restart cycle carries a valid byte that
        // must not be written.
        done_cnt = '{0, 0};
        pulse_ld_start();
        for (int i = 0; i < 5; i++) send_byte(8'hAA, 0);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'hAA;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'h55, 30);
        tick();
        chk("restart_done_once0", done_cnt[0], 1);
        chk("restart_done_once1", done_cnt[1], 1);
        check_image("restart_image", fives);

        // Reload from RUN with a fresh random image.
        pulse_ld_start();
        chk("run_reload_crst1", {31'h0, core_rst_n1}, 32'h0);
        for (int i = 0; i < 16; i++) send_byte(img2[i], 25);
        tick();
        chk("run_reload_crst1_after", {31'h0, core_rst_n1}, 32'h1);
        check_image("reload_image", img2);

        // Asynchronous reset after 8 bytes.
        pulse_ld_start();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_crst0",  {31'h0, core_rst_n0}, 32'h0);
        chk("areset_busy0",  {31'h0, busy0},       32'h0);
        chk("areset_ready1", {31'h0, ld_ready1},   32'h0);
        check_image("areset_zero", zeros);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("run_start_crst0", {31'h0, core_rst_n0}, 32'h1);
        chk("run_start_crst1", {31'h0, core_rst_n1}, 32'h1);
        ip = 4'd7; #1;
        chk("run_start_op0", {24'h0, op0}, 32'h0);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_td4_imem_loader
`default_nettype wire
